// File: rtl/ssd_scan_driver_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ssd_pkg;

    localparam int DIGITS = 4;

    typedef logic [7:0] seg_t;
    typedef logic [1:0] digit_idx_t;

    localparam seg_t             SEG_OFF = 8'hFF;
    localparam logic [DIGITS-1:0] AN_OFF = 4'hF;

    // Active-low one-hot anode pattern for a digit index
    function automatic logic [DIGITS-1:0] anode_for(digit_idx_t i);
        logic [DIGITS-1:0] one;
        one = 1;
        return ~(one << i);
    endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Bundle between the game core and the display scan driver (patterns in, pins out).
// Latency: n/a (wires only).
// Backpressure: none; patterns are sampled once per frame. Optional SSD_BLINK_EN adds blink_mask.
interface ssd_scan_driver_if;
    import ssd_pkg::*;

    seg_t              disp0;
    seg_t              disp1;
    seg_t              disp2;
    seg_t              disp3;
    logic [DIGITS-1:0] blank_mask;
`ifdef SSD_BLINK_EN
    logic [DIGITS-1:0] blink_mask;
`endif
    seg_t              seven;
    logic [DIGITS-1:0] segment;
    logic              frame_tick;

    modport master (
`ifdef SSD_BLINK_EN
        output blink_mask,
`endif
        output disp0, disp1, disp2, disp3, blank_mask,
        input  seven, segment, frame_tick
    );

    modport slave (
`ifdef SSD_BLINK_EN
        input  blink_mask,
`endif
        input  disp0, disp1, disp2, disp3, blank_mask,
        output seven, segment, frame_tick
    );

endinterface

// File: rtl/ssd_scan_driver_prescaler.sv
// Slot counter for the digit scan: flags the last cycle of a slot and the blanked head of a slot.
// Latency: flags are combinational from the counter register.
// Backpressure: none; free-running from reset.
module ssd_prescaler #(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYC    = 16
) (
    input  logic clk,
    input  logic rst,
    output logic slot_wrap,
    output logic in_dead
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] cnt;

    assign slot_wrap = (cnt == CW'(REFRESH_DIV - 1));

    // Count 0..REFRESH_DIV-1 and wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (slot_wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Zero dead time degenerates to a constant so no always-false compare is built
    generate
        if (DEAD_CYC == 0) begin : g_no_dead
            assign in_dead = 1'b0;
        end else begin : g_dead
            assign in_dead = (cnt < CW'(DEAD_CYC));
        end
    endgenerate

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with per-frame shadow latch and dead time.
// Latency: one clk from slot/idx state to pins, constant. Optional blink via SSD_BLINK_EN.
// Backpressure: none; inputs are sampled at frame start, mid-frame changes wait for next frame.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int DEAD_CYC     = 16,
    parameter int BLINK_FRAMES = 125
) (
    input  logic             clk,
    input  logic             rst,
    ssd_scan_driver_if.slave bus
);

    generate
        if (REFRESH_DIV < 2 || DEAD_CYC < 0 || DEAD_CYC >= REFRESH_DIV || BLINK_FRAMES < 1) begin : g_bad_cfg
            $error("ssd_scan_driver: need REFRESH_DIV >= 2, 0 <= DEAD_CYC < REFRESH_DIV, BLINK_FRAMES >= 1");
        end
    endgenerate

    logic                     slot_wrap;
    logic                     in_dead;
    digit_idx_t               idx;
    seg_t [DIGITS-1:0]        shadow;
    logic [DIGITS-1:0]        blank_sh;
    logic                     first;
    logic                     frame_wrap;
    logic                     latch;
    logic                     digit_dark;
    seg_t                     seven_q;
    logic [DIGITS-1:0]        segment_q;
    logic                     tick_q;

    ssd_prescaler #(
        .REFRESH_DIV (REFRESH_DIV),
        .DEAD_CYC    (DEAD_CYC)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .slot_wrap (slot_wrap),
        .in_dead   (in_dead)
    );

    assign frame_wrap = slot_wrap && (idx == digit_idx_t'(DIGITS - 1));
    // The first cycle out of reset also loads the frame so the display need not wait a whole frame
    assign latch      = first || frame_wrap;

`ifdef SSD_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DIGITS-1:0] blink_sh;
    logic              phase_on;
    logic [FW-1:0]     fcnt;

    // Frame counter toggles the blink phase every BLINK_FRAMES frames
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_on <= 1'b1;
            fcnt     <= '0;
        end else if (frame_wrap) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt     <= '0;
                phase_on <= ~phase_on;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    // Blink mask is captured with the frame so a digit never half-blinks within a frame
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_sh <= '0;
        end else if (latch) begin
            blink_sh <= bus.blink_mask;
        end
    end

    assign digit_dark = blank_sh[idx] | (~phase_on & blink_sh[idx]);
`else
    assign digit_dark = blank_sh[idx];
`endif

    // Digit index advance and coherent frame capture
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            shadow   <= '0;
            blank_sh <= '0;
            first    <= 1'b1;
        end else begin
            first <= 1'b0;
            if (slot_wrap) begin
                idx <= idx + digit_idx_t'(1);
            end
            if (latch) begin
                shadow   <= {bus.disp3, bus.disp2, bus.disp1, bus.disp0};
                blank_sh <= bus.blank_mask;
            end
        end
    end

    // Registered pin drive: dark during dead time, else one anode plus its pattern
    always_ff @(posedge clk) begin
        if (rst) begin
            seven_q   <= SEG_OFF;
            segment_q <= AN_OFF;
            tick_q    <= 1'b0;
        end else begin
            tick_q <= frame_wrap;
            if (in_dead) begin
                seven_q   <= SEG_OFF;
                segment_q <= AN_OFF;
            end else begin
                segment_q <= anode_for(idx);
                seven_q   <= digit_dark ? SEG_OFF : ~shadow[idx];
            end
        end
    end

    assign bus.seven      = seven_q;
    assign bus.segment    = segment_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with REFRESH_DIV=8, DEAD_CYC=2, BLINK_FRAMES=2.
// Expected pins are derived per cycle from slot/digit/frame arithmetic and per-frame input tables.
// Blink scenario is exercised only when SSD_BLINK_EN is defined.
module tb_ssd_scan_driver;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    // Per-frame view of the inputs the DUT should have latched
    logic [7:0] fd [0:7][0:3];
    logic [3:0] fb [0:7];
    logic [3:0] fk [0:7];

    ssd_scan_driver_if bus ();

    ssd_scan_driver #(
        .REFRESH_DIV  (8),
        .DEAD_CYC     (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    // Record current inputs as what frames f..7 will display
    task automatic set_frames(input int f);
        for (int i = f; i < 8; i++) begin
            fd[i][0] = bus.disp0;
            fd[i][1] = bus.disp1;
            fd[i][2] = bus.disp2;
            fd[i][3] = bus.disp3;
            fb[i]    = bus.blank_mask;
`ifdef SSD_BLINK_EN
            fk[i]    = bus.blink_mask;
`else
            fk[i]    = 4'h0;
`endif
        end
    endtask

    // Check pins sampled after scan edges k0..k1 (edge 0 = first edge after reset release)
    task automatic scan(input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            int         f, d, c;
            logic       poff, dark;
            logic [7:0] es;
            logic [3:0] ea;
            logic [3:0] one;
            @(negedge clk);
            f   = k / 32;
            d   = (k / 8) % 4;
            c   = k % 8;
`ifdef SSD_BLINK_EN
            poff = ((f / 2) % 2) == 1;
`else
            poff = 1'b0;
`endif
            one = 4'b0001;
            if (c < 2) begin
                es = 8'hFF;
                ea = 4'hF;
            end else begin
                ea   = ~(one << d);
                dark = fb[f][d] | (poff & fk[f][d]);
                es   = dark ? 8'hFF : ~fd[f][d];
            end
            chk("segment", k, {4'h0, bus.segment}, {4'h0, ea});
            chk("seven", k, bus.seven, es);
            chk("frame_tick", k, {7'h0, bus.frame_tick}, {7'h0, (k % 32) == 31});
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.disp0      = 8'h3F;
        bus.disp1      = 8'h06;
        bus.disp2      = 8'h5B;
        bus.disp3      = 8'h4F;
        bus.blank_mask = 4'h0;
`ifdef SSD_BLINK_EN
        bus.blink_mask = 4'h0;
`endif
        set_frames(0);

        // Reset held three cycles
        repeat (3) @(negedge clk);
        chk("rst_seven", -1, bus.seven, 8'hFF);
        chk("rst_segment", -1, {4'h0, bus.segment}, 8'h0F);
        chk("rst_tick", -1, {7'h0, bus.frame_tick}, 8'h00);
        rst = 1'b0;

        // First frame; digit2 changes during digit1 slot and must not tear
        scan(0, 10);
        bus.disp2 = 8'h66;
        set_frames(1);
        scan(11, 40);

        // Blank digit2 from the next frame on
        bus.blank_mask = 4'b0100;
        set_frames(2);
        scan(41, 116);

        // Reset in the middle of the digit2 slot
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_seven", -2, bus.seven, 8'hFF);
        chk("midrst_segment", -2, {4'h0, bus.segment}, 8'h0F);
        chk("midrst_tick", -2, {7'h0, bus.frame_tick}, 8'h00);
        bus.blank_mask = 4'h0;
`ifdef SSD_BLINK_EN
        bus.blink_mask = 4'b0001;
`endif
        set_frames(0);
        rst = 1'b0;

        // Restart at digit0; with blink, digit0 lit 2 frames then dark 2 frames
        scan(0, 164);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
